// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - 5-stage pipeline sequencer: fetch PC, stage enables/flushes, hazard counters.
// Optional operand forwarding selects are built when HAZARD_FORWARDING_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int PC_W       = 5,
  parameter int FILL_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             freeze,
  input  logic [4:0]       id_rs_addr,
  input  logic [4:0]       id_rt_addr,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt_addr,
  input  logic             mem_branch_taken,
  input  logic [PC_W-1:0]  mem_branch_addr,
`ifdef HAZARD_FORWARDING_EN
  input  logic             ex_mem_regwrite,
  input  logic [4:0]       ex_mem_rd,
  input  logic             mem_wb_regwrite,
  input  logic [4:0]       mem_wb_rd,
  input  logic [4:0]       id_ex_rs,
  input  logic [4:0]       id_ex_rt,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
`endif
  output logic [PC_W-1:0]  pc_fetch,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             fill_done,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int FC_W = $clog2(FILL_DEPTH + 1);
  localparam logic [FC_W-1:0] FILL_LAST = FC_W'(FILL_DEPTH - 1);

  typedef enum logic [1:0] {S_FILL, S_RUN, S_FROZEN} state_t;

  state_t            state_q, state_d;
  state_t            saved_q, saved_d;
  state_t            eff_state;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [FC_W-1:0]   fill_cnt_q, fill_cnt_d;
  logic              fill_done_q, fill_done_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  flush_q, flush_d;
  logic              hz;

  assign hz = ex_mem_read && (ex_rt_addr != 5'd0) &&
              ((ex_rt_addr == id_rs_addr) || (id_uses_rt && (ex_rt_addr == id_rt_addr)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FILL;
      saved_q     <= S_FILL;
      pc_q        <= '0;
      fill_cnt_q  <= '0;
      fill_done_q <= 1'b0;
      stall_q     <= '0;
      flush_q     <= '0;
    end else begin
      state_q     <= state_d;
      saved_q     <= saved_d;
      pc_q        <= pc_d;
      fill_cnt_q  <= fill_cnt_d;
      fill_done_q <= fill_done_d;
      stall_q     <= stall_d;
      flush_q     <= flush_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    saved_d      = saved_q;
    pc_d         = pc_q;
    fill_cnt_d   = fill_cnt_q;
    fill_done_d  = fill_done_q;
    stall_d      = stall_q;
    flush_d      = flush_q;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    // FROZEN acts as its saved state on the first cycle freeze drops, so no resume cycle is lost.
    eff_state    = (state_q == S_FROZEN) ? saved_q : state_q;

    if (reset) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (freeze) begin
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
      state_d   = S_FROZEN;
      saved_d   = eff_state;
    end else begin
      state_d = eff_state;
      if (eff_state == S_FILL) begin
        fill_cnt_d = fill_cnt_q + 1'b1;
        if (fill_cnt_q == FILL_LAST) begin
          state_d     = S_RUN;
          fill_done_d = 1'b1;
        end
      end
      if (mem_branch_taken) begin
        pc_d         = mem_branch_addr;
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
        flush_d      = (flush_q == '1) ? flush_q : flush_q + 1'b1;
      end else if (hz) begin
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
        stall_d     = (stall_q == '1) ? stall_q : stall_q + 1'b1;
      end else begin
        pc_d = pc_q + 1'b1;
      end
    end
  end

`ifdef HAZARD_FORWARDING_EN
  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (ex_mem_regwrite && (ex_mem_rd != 5'd0) && (ex_mem_rd == src))
      return 2'b10;
    else if (mem_wb_regwrite && (mem_wb_rd != 5'd0) && (mem_wb_rd == src))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    fwd_a = fwd_sel(id_ex_rs);
    fwd_b = fwd_sel(id_ex_rt);
  end
`else
  // Without forwarding, non-load RAW hazards are left to instruction scheduling.
`endif

  assign pc_fetch    = pc_q;
  assign fill_done   = fill_done_q;
  assign stall_count = stall_q;
  assign flush_count = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed vector bench for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset, freeze;
  logic [4:0] id_rs_addr, id_rt_addr, ex_rt_addr, mem_branch_addr;
  logic       id_uses_rt, ex_mem_read, mem_branch_taken;
  logic [4:0] pc_fetch;
  logic       if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic       if_id_flush, id_ex_flush, ex_mem_flush, fill_done;
  logic [7:0] stall_count, flush_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       fz;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       ur;
    logic       mr;
    logic [4:0] ert;
    logic       br;
    logic [4:0] ba;
    logic [4:0] pc;
    logic [3:0] en;
    logic [2:0] fl;
    logic       fd;
    logic [7:0] sc;
    logic [7:0] fc;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk(clk), .reset(reset), .freeze(freeze),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt_addr(ex_rt_addr),
    .mem_branch_taken(mem_branch_taken), .mem_branch_addr(mem_branch_addr),
    .pc_fetch(pc_fetch),
    .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .fill_done(fill_done), .stall_count(stall_count), .flush_count(flush_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic fz, input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                     input logic mr, input logic [4:0] ert, input logic br, input logic [4:0] ba,
                     input logic [4:0] pc, input logic [3:0] en, input logic [2:0] fl,
                     input logic fd, input logic [7:0] sc, input logic [7:0] fc);
    vec_t v;
    v.fz = fz; v.rs = rs; v.rt = rt; v.ur = ur; v.mr = mr; v.ert = ert; v.br = br; v.ba = ba;
    v.pc = pc; v.en = en; v.fl = fl; v.fd = fd; v.sc = sc; v.fc = fc;
    vecs.push_back(v);
  endtask

  task automatic add_idle(input logic [4:0] pc, input logic fd, input logic [7:0] sc, input logic [7:0] fc);
    add(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, pc, 4'b1111, 3'b000, fd, sc, fc);
  endtask

  task automatic set_in(input vec_t v);
    freeze = v.fz; id_rs_addr = v.rs; id_rt_addr = v.rt; id_uses_rt = v.ur;
    ex_mem_read = v.mr; ex_rt_addr = v.ert; mem_branch_taken = v.br; mem_branch_addr = v.ba;
  endtask

  function automatic logic [3:0] en_vec();
    return {if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
  endfunction

  function automatic logic [2:0] fl_vec();
    return {if_id_flush, id_ex_flush, ex_mem_flush};
  endfunction

  initial begin
    vec_t idle;
    // Post-reset fill: fill_done appears after the fourth edge.
    add_idle(5'd0, 1'b0, 8'd0, 8'd0);
    add_idle(5'd1, 1'b0, 8'd0, 8'd0);
    add_idle(5'd2, 1'b0, 8'd0, 8'd0);
    add_idle(5'd3, 1'b0, 8'd0, 8'd0);
    add_idle(5'd4, 1'b1, 8'd0, 8'd0);
    add_idle(5'd5, 1'b1, 8'd0, 8'd0);
    add(1'b0, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 5'd0, 5'd6,  4'b0111, 3'b010, 1'b1, 8'd0, 8'd0);
    add(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 5'd6,  4'b1111, 3'b000, 1'b1, 8'd1, 8'd0);
    add(1'b0, 5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 5'd7,  4'b0111, 3'b010, 1'b1, 8'd1, 8'd0);
    add(1'b0, 5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 5'd0, 5'd7,  4'b1111, 3'b000, 1'b1, 8'd2, 8'd0);
    add_idle(5'd8, 1'b1, 8'd2, 8'd0);
    add(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd17, 5'd9, 4'b1111, 3'b111, 1'b1, 8'd2, 8'd0);
    add_idle(5'd17, 1'b1, 8'd2, 8'd1);
    add(1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 5'd3, 5'd18,  4'b1111, 3'b111, 1'b1, 8'd2, 8'd1);
    add_idle(5'd3, 1'b1, 8'd2, 8'd2);
    add(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd20, 5'd4, 4'b1111, 3'b111, 1'b1, 8'd2, 8'd2);
    add(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 5'd20,  4'b0000, 3'b000, 1'b1, 8'd2, 8'd3);
    add(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 5'd20,  4'b0000, 3'b000, 1'b1, 8'd2, 8'd3);
    add(1'b1, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 5'd0, 5'd20,  4'b0000, 3'b000, 1'b1, 8'd2, 8'd3);
    add_idle(5'd20, 1'b1, 8'd2, 8'd3);
    add_idle(5'd21, 1'b1, 8'd2, 8'd3);
    add(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd31, 5'd22, 4'b1111, 3'b111, 1'b1, 8'd2, 8'd3);
    add_idle(5'd31, 1'b1, 8'd2, 8'd4);
    add_idle(5'd0,  1'b1, 8'd2, 8'd4);

    idle = vecs[0];
    set_in(idle);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("reset_en", 32'(en_vec()), 32'hf);
    chk("reset_fl", 32'(fl_vec()), 32'h7);
    @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_pc", 32'(pc_fetch), 32'd0);
    chk("reset_fd", 32'(fill_done), 32'd0);
    chk("reset_sc", 32'(stall_count), 32'd0);
    chk("reset_fc", 32'(flush_count), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      set_in(vecs[i]);
      @(negedge clk);
      chk($sformatf("v%0d_pc", i), 32'(pc_fetch), 32'(vecs[i].pc));
      chk($sformatf("v%0d_en", i), 32'(en_vec()), 32'(vecs[i].en));
      chk($sformatf("v%0d_fl", i), 32'(fl_vec()), 32'(vecs[i].fl));
      chk($sformatf("v%0d_fd", i), 32'(fill_done), 32'(vecs[i].fd));
      chk($sformatf("v%0d_sc", i), 32'(stall_count), 32'(vecs[i].sc));
      chk($sformatf("v%0d_fc", i), 32'(flush_count), 32'(vecs[i].fc));
      @(posedge clk);
      #1;
    end

    // Continuous load-use hazard: PC holds at 1, stall counter saturates.
    set_in(idle);
    ex_mem_read = 1'b1; ex_rt_addr = 5'd8; id_rs_addr = 5'd8;
    repeat (300) @(posedge clk);
    #1;
    chk("sat_sc", 32'(stall_count), 32'd255);
    chk("sat_pc", 32'(pc_fetch), 32'd1);
    chk("sat_fc", 32'(flush_count), 32'd4);
    @(negedge clk);
    chk("sat_en", 32'(en_vec()), 32'h7);

    // Reset during the stall overrides the hazard.
    reset = 1'b1;
    @(negedge clk);
    chk("rst2_en", 32'(en_vec()), 32'hf);
    chk("rst2_fl", 32'(fl_vec()), 32'h7);
    @(posedge clk);
    #1 reset = 1'b0;
    set_in(idle);
    chk("rst2_pc", 32'(pc_fetch), 32'd0);
    chk("rst2_sc", 32'(stall_count), 32'd0);
    chk("rst2_fc", 32'(flush_count), 32'd0);
    chk("rst2_fd", 32'(fill_done), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("refill_fd3", 32'(fill_done), 32'd0);
    @(posedge clk);
    #1;
    chk("refill_fd4", 32'(fill_done), 32'd1);
    chk("refill_pc4", 32'(pc_fetch), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
